multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the MIPS-subset CPU (LUI, ORI, SW, LW, BEQ, J, NOR, ADD).
//  Steps the shared datapath through FETCH/DECODE/EXEC/MEM/WB with ready handshakes to I-mem and D-mem.
//  Drives the datapath mux selects cu_c1..c4, the ALU command cu_cA, PC/IR/reg/mem write strobes and a retire counter.
//  Opcode/func encodings are the INST_*/FUNC_* values in macro.vh; ALU codes are the ALU_* values.
// PARAMETERS
//  TIMEOUT  16  max cycles to wait for i_ready/d_ready before a bus error (>=1)
//  CNT_W    32  width of the retired-instruction counter
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      synchronous reset, active-high
//  run          in   1      1 = allowed to start a new FETCH
//  opcode       in   6      IR[31:26], valid from DECODE onward
//  func         in   6      IR[5:0]
//  alu_zero     in   1      ALU result == 0
//  i_ready      in   1      I-mem data valid this cycle
//  d_ready      in   1      D-mem access complete this cycle
//  i_req        out  1      I-mem read request
//  d_req        out  1      D-mem request
//  d_we         out  1      D-mem write (only with d_req)
//  ir_we        out  1      latch IR
//  pc_we        out  1      update PC
//  pc_src       out  2      0=PC+4, 1=branch target, 2=jump target
//  reg_we       out  1      register-file write
//  cu_c1..cu_c4 out  1 ea   c1 imm/rt->alu_in2, c2 rd/rt dest, c3 imm/rs (always 0), c4 d_rdata/alu wd
//  cu_cA        out  4      ALU command
//  state        out  3      current state, for debug
//  retired      out  CNT_W  instructions completed since reset
//  bus_err      out  1      sticky, set on handshake timeout
// BEHAVIOUR
//  Reset: state=FETCH, retired=0, bus_err=0, wait cnt=0; all strobes (i_req,d_req,d_we,ir_we,pc_we,reg_we)=0 and cu_*=0 in the reset cycle.
//  Strobes are combinational from (state, latched inst_id, handshake inputs); inst_id is latched in DECODE and held until the next DECODE.
//  States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=7.
//  FETCH: if run=0, idle (i_req=0, no wait count). Else i_req=1; on i_ready: ir_we=1, pc_we=1, pc_src=0 -> DECODE.
//  DECODE: latch inst_id. J: pc_we=1, pc_src=2, retire -> FETCH. Unknown opcode/func: retire as NOP -> FETCH. Else -> EXEC.
//  EXEC: cu_cA valid. BEQ: if alu_zero, pc_we=1 with pc_src=1; retire -> FETCH. LW/SW -> MEM. ADD/NOR/ORI/LUI -> WB.
//  MEM: d_req=1, d_we=1 for SW. On d_ready: SW retires -> FETCH; LW -> WB.
//  WB: reg_we=1 for exactly one cycle, retire -> FETCH.
//  Decode values, held EXEC..WB:
//   - cu_c1=1 for LUI/ORI/SW/LW; cu_c2=1 for ADD/NOR; cu_c3=0; cu_c4=1 for LW.
//   - cu_cA: ALU_ADD for SW/LW/ADD, ALU_LUI, ALU_SUB for BEQ, ALU_OR for ORI, ALU_NOR for NOR, else ALU_NULL.
//  Handshakes: i_req/d_req stay high until ready; ready while req=0 is ignored.
//  Timeout: the wait counter clears on state entry and counts each requesting cycle without ready.
//   If it reaches TIMEOUT: bus_err=1 -> HALT. HALT drives all strobes 0 and exits only via rst.
//  retired: +1 on each retire event; wraps at 2^CNT_W-1 -> 0.
//  Latency with zero-wait memory: J 2, BEQ 3, ALU ops 4, SW 4, LW 5 cycles.
//  run deassert mid-instruction: the instruction completes; it blocks only the next FETCH.
//  rst mid-MEM: d_req drops the same cycle, no reg write; restart at FETCH.
// TESTING
//  - rst, run=1, i_ready=1, ADD: states 0,1,2,4,0. reg_we=1 only in WB, cu_c2=1, cu_cA=ALU_ADD, retired=1.
//  - LW, d_ready delayed 3 cycles: d_req high 4 cycles, d_we=0. Then WB with cu_c4=1, reg_we=1. 8 cycles total.
//  - BEQ with alu_zero=1: pc_we=1, pc_src=1 in EXEC. With alu_zero=0: pc_we=0. Both retire in 3 cycles.
//  - J: pc_src=2 in DECODE, next state FETCH. Unknown opcode 6'h3F: no writes, retired+1.
//  - TIMEOUT=4, SW, d_ready held 0: bus_err=1 after 4 MEM cycles, state=7, strobes 0. Only rst clears.
//  - run=0 in FETCH: i_req=0 indefinitely. rst asserted mid-MEM: next cycle state=0, d_req=0, retired=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for a MIPS-subset CPU: steps the shared datapath through
// FETCH/DECODE/EXEC/MEM/WB with ready handshakes to instruction and data memory.
//
//  state  | meaning
//  FETCH  | request I-mem word, latch IR and advance PC on i_ready
//  DECODE | classify opcode/func; jumps and unknown encodings retire here
//  EXEC   | ALU command valid; BEQ resolves and retires here
//  MEM    | D-mem access for LW/SW
//  WB     | single-cycle register-file write
//  HALT   | handshake timeout, left only through rst
module multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             alu_zero,
    input  logic             i_ready,
    input  logic             d_ready,
    output logic             i_req,
    output logic             d_req,
    output logic             d_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             reg_we,
    output logic             cu_c1,
    output logic             cu_c2,
    output logic             cu_c3,
    output logic             cu_c4,
    output logic [3:0]       cu_cA,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             bus_err
);

    localparam logic [5:0] INST_RTYPE = 6'h00;
    localparam logic [5:0] INST_J     = 6'h02;
    localparam logic [5:0] INST_BEQ   = 6'h04;
    localparam logic [5:0] INST_ORI   = 6'h0D;
    localparam logic [5:0] INST_LUI   = 6'h0F;
    localparam logic [5:0] INST_LW    = 6'h23;
    localparam logic [5:0] INST_SW    = 6'h2B;
    localparam logic [5:0] FUNC_ADD   = 6'h20;
    localparam logic [5:0] FUNC_NOR   = 6'h27;

    localparam logic [3:0] ALU_NULL = 4'h0;
    localparam logic [3:0] ALU_ADD  = 4'h1;
    localparam logic [3:0] ALU_SUB  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_NOR  = 4'h4;
    localparam logic [3:0] ALU_LUI  = 4'h5;

    localparam int              WAIT_W     = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        ID_NOP, ID_LUI, ID_ORI, ID_SW, ID_LW, ID_BEQ, ID_J, ID_NOR, ID_ADD
    } inst_t;

    state_t            r_state;
    state_t            w_state_next;
    inst_t             r_inst_id;
    inst_t             w_inst_id;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_inc;
    logic [CNT_W-1:0]  r_retired;
    logic              r_bus_err;

    logic       w_i_req;
    logic       w_d_req;
    logic       w_d_we;
    logic       w_ir_we;
    logic       w_pc_we;
    logic [1:0] w_pc_src;
    logic       w_reg_we;
    logic       w_cu_en;
    logic       w_retire;
    logic       w_waiting;
    logic       w_timeout;

    logic       w_dec_c1;
    logic       w_dec_c2;
    logic       w_dec_c4;
    logic [3:0] w_dec_cA;

    always_comb begin
        w_inst_id = ID_NOP;
        case (opcode)
            INST_RTYPE: begin
                if (func == FUNC_ADD) begin
                    w_inst_id = ID_ADD;
                end else if (func == FUNC_NOR) begin
                    w_inst_id = ID_NOR;
                end
            end
            INST_J:   w_inst_id = ID_J;
            INST_BEQ: w_inst_id = ID_BEQ;
            INST_ORI: w_inst_id = ID_ORI;
            INST_LUI: w_inst_id = ID_LUI;
            INST_LW:  w_inst_id = ID_LW;
            INST_SW:  w_inst_id = ID_SW;
            default:  w_inst_id = ID_NOP;
        endcase
    end

    // Datapath selects come from the instruction latched in DECODE, so they
    // stay stable through EXEC, MEM and WB even if IR bits change.
    always_comb begin
        w_dec_c1 = 1'b0;
        w_dec_c2 = 1'b0;
        w_dec_c4 = 1'b0;
        w_dec_cA = ALU_NULL;
        case (r_inst_id)
            ID_LUI: begin w_dec_c1 = 1'b1; w_dec_cA = ALU_LUI; end
            ID_ORI: begin w_dec_c1 = 1'b1; w_dec_cA = ALU_OR;  end
            ID_SW:  begin w_dec_c1 = 1'b1; w_dec_cA = ALU_ADD; end
            ID_LW:  begin w_dec_c1 = 1'b1; w_dec_c4 = 1'b1; w_dec_cA = ALU_ADD; end
            ID_BEQ: w_dec_cA = ALU_SUB;
            ID_NOR: begin w_dec_c2 = 1'b1; w_dec_cA = ALU_NOR; end
            ID_ADD: begin w_dec_c2 = 1'b1; w_dec_cA = ALU_ADD; end
            default: w_dec_cA = ALU_NULL;
        endcase
    end

    assign w_wait_inc = r_wait + WAIT_W'(1);

    always_comb begin
        w_state_next = r_state;
        w_i_req      = 1'b0;
        w_d_req      = 1'b0;
        w_d_we       = 1'b0;
        w_ir_we      = 1'b0;
        w_pc_we      = 1'b0;
        w_pc_src     = 2'd0;
        w_reg_we     = 1'b0;
        w_cu_en      = 1'b0;
        w_retire     = 1'b0;
        w_waiting    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (run) begin
                    w_i_req = 1'b1;
                    if (i_ready) begin
                        w_ir_we      = 1'b1;
                        w_pc_we      = 1'b1;
                        w_state_next = S_DECODE;
                    end else begin
                        w_waiting = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                case (w_inst_id)
                    ID_J: begin
                        w_pc_we      = 1'b1;
                        w_pc_src     = 2'd2;
                        w_retire     = 1'b1;
                        w_state_next = S_FETCH;
                    end
                    ID_NOP: begin
                        w_retire     = 1'b1;
                        w_state_next = S_FETCH;
                    end
                    default: w_state_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                w_cu_en = 1'b1;
                case (r_inst_id)
                    ID_BEQ: begin
                        w_pc_we      = alu_zero;
                        w_pc_src     = 2'd1;
                        w_retire     = 1'b1;
                        w_state_next = S_FETCH;
                    end
                    ID_SW, ID_LW: w_state_next = S_MEM;
                    default:      w_state_next = S_WB;
                endcase
            end
            S_MEM: begin
                w_cu_en = 1'b1;
                w_d_req = 1'b1;
                w_d_we  = (r_inst_id == ID_SW);
                if (d_ready) begin
                    if (r_inst_id == ID_SW) begin
                        w_retire     = 1'b1;
                        w_state_next = S_FETCH;
                    end else begin
                        w_state_next = S_WB;
                    end
                end else begin
                    w_waiting = 1'b1;
                end
            end
            S_WB: begin
                w_cu_en      = 1'b1;
                w_reg_we     = 1'b1;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_HALT:  w_state_next = S_HALT;
            default: w_state_next = S_FETCH;
        endcase
        if (w_waiting && (w_wait_inc == WAIT_LIMIT)) begin
            w_timeout    = 1'b1;
            w_state_next = S_HALT;
        end
    end

    // The wait counter only ever counts inside one state, so any transition clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_inst_id <= ID_NOP;
            r_wait    <= '0;
            r_retired <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_DECODE) begin
                r_inst_id <= w_inst_id;
            end
            if (w_state_next != r_state) begin
                r_wait <= '0;
            end else if (w_waiting) begin
                r_wait <= w_wait_inc;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    // Strobes are forced low during the reset cycle so a reset mid-access drops them at once.
    assign i_req   = w_i_req  & ~rst;
    assign d_req   = w_d_req  & ~rst;
    assign d_we    = w_d_we   & ~rst;
    assign ir_we   = w_ir_we  & ~rst;
    assign pc_we   = w_pc_we  & ~rst;
    assign pc_src  = w_pc_src & {2{~rst}};
    assign reg_we  = w_reg_we & ~rst;
    assign cu_c1   = w_dec_c1 & w_cu_en & ~rst;
    assign cu_c2   = w_dec_c2 & w_cu_en & ~rst;
    assign cu_c3   = 1'b0;
    assign cu_c4   = w_dec_c4 & w_cu_en & ~rst;
    assign cu_cA   = w_dec_cA & {4{w_cu_en & ~rst}};
    assign state   = r_state;
    assign retired = r_retired;
    assign bus_err = r_bus_err;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus random instruction streams,
// each instruction expanded into an expected per-cycle trace from its class and memory delays.
module tb_multicycle_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ORI = 6'h0D;
    localparam logic [5:0] OP_LUI = 6'h0F;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_NOR = 6'h27;

    localparam logic [3:0] A_NULL = 4'h0;
    localparam logic [3:0] A_ADD  = 4'h1;
    localparam logic [3:0] A_SUB  = 4'h2;
    localparam logic [3:0] A_OR   = 4'h3;
    localparam logic [3:0] A_NOR  = 4'h4;
    localparam logic [3:0] A_LUI  = 4'h5;

    localparam int K_NOP = 0, K_LUI = 1, K_ORI = 2, K_SW = 3, K_LW = 4;
    localparam int K_BEQ = 5, K_J = 6, K_NOR = 7, K_ADD = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic [5:0]       opcode;
    logic [5:0]       func;
    logic             alu_zero;
    logic             i_ready;
    logic             d_ready;
    logic             i_req;
    logic             d_req;
    logic             d_we;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_src;
    logic             reg_we;
    logic             cu_c1;
    logic             cu_c2;
    logic             cu_c3;
    logic             cu_c4;
    logic [3:0]       cu_cA;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;
    logic             bus_err;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .func(func),
        .alu_zero(alu_zero), .i_ready(i_ready), .d_ready(d_ready),
        .i_req(i_req), .d_req(d_req), .d_we(d_we), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
        .cu_c1(cu_c1), .cu_c2(cu_c2), .cu_c3(cu_c3), .cu_c4(cu_c4),
        .cu_cA(cu_cA), .state(state), .retired(retired), .bus_err(bus_err)
    );

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic [2:0] st;
        logic       run;
        logic       irdy;
        logic       drdy;
        logic       zero;
        logic       i_req;
        logic       d_req;
        logic       d_we;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       reg_we;
        logic       c1;
        logic       c2;
        logic       c4;
        logic [3:0] ca;
        logic       retire;
    } cyc_t;

    cyc_t             plan_q[$];
    int               errors = 0;
    int               checks = 0;
    logic [CNT_W-1:0] exp_ret;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_R:    return (fn == FN_ADD) ? K_ADD : (fn == FN_NOR) ? K_NOR : K_NOP;
            OP_J:    return K_J;
            OP_BEQ:  return K_BEQ;
            OP_ORI:  return K_ORI;
            OP_LUI:  return K_LUI;
            OP_LW:   return K_LW;
            OP_SW:   return K_SW;
            default: return K_NOP;
        endcase
    endfunction

    function automatic cyc_t blank(input logic [5:0] op, input logic [5:0] fn,
                                   input logic [2:0] st, input logic r, input logic z);
        cyc_t c;
        c = '{op: op, fn: fn, st: st, run: r, zero: z, pc_src: 2'd0, ca: A_NULL, default: 1'b0};
        return c;
    endfunction

    // Expected cycle trace: FETCH waits di cycles, MEM waits dd cycles, then the class path.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int di, input int dd, input logic run_after);
        cyc_t       c;
        int         k;
        logic       c1, c2, c4;
        logic [3:0] ca;
        k  = classify(op, fn);
        c1 = (k == K_LUI) || (k == K_ORI) || (k == K_SW) || (k == K_LW);
        c2 = (k == K_ADD) || (k == K_NOR);
        c4 = (k == K_LW);
        ca = (k == K_SW || k == K_LW || k == K_ADD) ? A_ADD :
             (k == K_LUI) ? A_LUI : (k == K_BEQ) ? A_SUB :
             (k == K_ORI) ? A_OR  : (k == K_NOR) ? A_NOR : A_NULL;
        plan_q.delete();
        for (int i = 0; i <= di; i++) begin
            c = blank(op, fn, 3'd0, 1'b1, z);
            c.i_req = 1'b1;
            c.irdy  = (i == di);
            c.ir_we = (i == di);
            c.pc_we = (i == di);
            plan_q.push_back(c);
        end
        c = blank(op, fn, 3'd1, run_after, z);
        if (k == K_J) begin
            c.pc_we = 1'b1; c.pc_src = 2'd2; c.retire = 1'b1;
        end
        if (k == K_NOP) c.retire = 1'b1;
        plan_q.push_back(c);
        if (k == K_J || k == K_NOP) return;
        c = blank(op, fn, 3'd2, run_after, z);
        c.c1 = c1; c.c2 = c2; c.c4 = c4; c.ca = ca;
        if (k == K_BEQ) begin
            c.pc_we = z; c.pc_src = 2'd1; c.retire = 1'b1;
            plan_q.push_back(c);
            return;
        end
        plan_q.push_back(c);
        if (k == K_SW || k == K_LW) begin
            for (int i = 0; i <= dd; i++) begin
                c = blank(op, fn, 3'd3, run_after, z);
                c.c1 = c1; c.c2 = c2; c.c4 = c4; c.ca = ca;
                c.d_req  = 1'b1;
                c.d_we   = (k == K_SW);
                c.drdy   = (i == dd);
                c.retire = (k == K_SW) && (i == dd);
                plan_q.push_back(c);
            end
            if (k == K_SW) return;
        end
        c = blank(op, fn, 3'd4, run_after, z);
        c.c1 = c1; c.c2 = c2; c.c4 = c4; c.ca = ca;
        c.reg_we = 1'b1; c.retire = 1'b1;
        plan_q.push_back(c);
    endtask

    task automatic run_plan(input int n);
        cyc_t c;
        for (int k = 0; k < n && k < plan_q.size(); k++) begin
            c = plan_q[k];
            @(negedge clk);
            opcode = c.op; func = c.fn; run = c.run;
            i_ready = c.irdy; d_ready = c.drdy; alu_zero = c.zero;
            #1;
            chk("state",   32'(state),   32'(c.st));
            chk("i_req",   32'(i_req),   32'(c.i_req));
            chk("d_req",   32'(d_req),   32'(c.d_req));
            chk("d_we",    32'(d_we),    32'(c.d_we));
            chk("ir_we",   32'(ir_we),   32'(c.ir_we));
            chk("pc_we",   32'(pc_we),   32'(c.pc_we));
            chk("reg_we",  32'(reg_we),  32'(c.reg_we));
            chk("cu_c1",   32'(cu_c1),   32'(c.c1));
            chk("cu_c2",   32'(cu_c2),   32'(c.c2));
            chk("cu_c3",   32'(cu_c3),   32'd0);
            chk("cu_c4",   32'(cu_c4),   32'(c.c4));
            chk("cu_cA",   32'(cu_cA),   32'(c.ca));
            chk("retired", 32'(retired), 32'(exp_ret));
            chk("bus_err", 32'(bus_err), 32'd0);
            if (c.pc_we) chk("pc_src", 32'(pc_src), 32'(c.pc_src));
            if (c.retire) exp_ret = exp_ret + 1'b1;
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_i_req"},  32'(i_req),  32'd0);
        chk({tag, "_d_req"},  32'(d_req),  32'd0);
        chk({tag, "_d_we"},   32'(d_we),   32'd0);
        chk({tag, "_ir_we"},  32'(ir_we),  32'd0);
        chk({tag, "_pc_we"},  32'(pc_we),  32'd0);
        chk({tag, "_reg_we"}, 32'(reg_we), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; run = 1'b1; i_ready = 1'b1; d_ready = 1'b1; alu_zero = 1'b1;
        #1;
        chk_quiet("rst_cycle");
        chk("rst_cycle_cu", 32'({cu_c1, cu_c2, cu_c3, cu_c4, cu_cA}), 32'd0);
        @(negedge clk);
        rst = 1'b0; run = 1'b0; i_ready = 1'b0; d_ready = 1'b0;
        #1;
        chk("rst_state",   32'(state),   32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk_quiet("rst_after");
        exp_ret = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] ops [10];
        logic [5:0] fns [10];
        int         sel;
        rst = 1'b1; run = 1'b0; opcode = '0; func = '0;
        alu_zero = 1'b0; i_ready = 1'b0; d_ready = 1'b0;
        exp_ret = '0;
        do_reset();

        build(OP_R, FN_ADD, 1'b0, 0, 0, 1'b1);      run_plan(plan_q.size());
        build(OP_LW, 6'h11, 1'b0, 0, 3, 1'b1);      run_plan(plan_q.size());
        build(OP_BEQ, 6'h00, 1'b1, 0, 0, 1'b1);     run_plan(plan_q.size());
        build(OP_BEQ, 6'h00, 1'b0, 0, 0, 1'b1);     run_plan(plan_q.size());
        build(OP_J, 6'h05, 1'b0, 1, 0, 1'b1);       run_plan(plan_q.size());
        build(6'h3F, 6'h00, 1'b0, 0, 0, 1'b1);      run_plan(plan_q.size());
        build(OP_R, 6'h08, 1'b0, 0, 0, 1'b1);       run_plan(plan_q.size());
        build(OP_SW, 6'h00, 1'b0, 2, 1, 1'b1);      run_plan(plan_q.size());

        // run dropped after the fetch: instruction finishes, next fetch is held off
        build(OP_ORI, 6'h2A, 1'b0, 0, 0, 1'b0);     run_plan(plan_q.size());
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            run = 1'b0; i_ready = 1'b1; d_ready = 1'b1;
            #1;
            chk("idle_state",   32'(state),   32'd0);
            chk("idle_retired", 32'(retired), 32'(exp_ret));
            chk_quiet("idle");
        end

        ops = '{OP_LUI, OP_ORI, OP_SW, OP_LW, OP_BEQ, OP_J, OP_R, OP_R, OP_R, 6'h3F};
        fns = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, FN_ADD, FN_NOR, 6'h08, 6'h00};
        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(9);
            build(ops[sel], (ops[sel] == OP_R) ? fns[sel] : 6'($urandom),
                  1'($urandom), $urandom_range(TIMEOUT - 1), $urandom_range(TIMEOUT - 1), 1'b1);
            run_plan(plan_q.size());
        end

        // reset in the middle of a load
        build(OP_LW, 6'h00, 1'b0, 0, 3, 1'b1);
        run_plan(4);
        @(negedge clk);
        rst = 1'b1; d_ready = 1'b0;
        #1;
        chk_quiet("rst_mem");
        @(negedge clk);
        rst = 1'b0; run = 1'b0;
        #1;
        chk("rst_mem_state",   32'(state),   32'd0);
        chk("rst_mem_retired", 32'(retired), 32'd0);
        chk_quiet("rst_mem_after");
        exp_ret = '0;

        // instruction fetch never answered
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            run = 1'b1; i_ready = 1'b0;
            #1;
            chk("ifetch_wait_state", 32'(state),   32'd0);
            chk("ifetch_wait_i_req", 32'(i_req),   32'd1);
            chk("ifetch_wait_err",   32'(bus_err), 32'd0);
        end
        @(negedge clk);
        #1;
        chk("ifetch_to_state", 32'(state),   32'd7);
        chk("ifetch_to_err",   32'(bus_err), 32'd1);
        chk_quiet("ifetch_halt");
        do_reset();

        // store never answered
        build(OP_R, FN_NOR, 1'b0, 0, 0, 1'b1);     run_plan(plan_q.size());
        build(OP_SW, 6'h00, 1'b0, 0, 0, 1'b1);
        run_plan(3);
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            d_ready = 1'b0;
            #1;
            chk("sw_wait_state", 32'(state),   32'd3);
            chk("sw_wait_d_req", 32'(d_req),   32'd1);
            chk("sw_wait_d_we",  32'(d_we),    32'd1);
            chk("sw_wait_err",   32'(bus_err), 32'd0);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            run = 1'b1; i_ready = 1'b1; d_ready = 1'b1;
            #1;
            chk("halt_state",   32'(state),   32'd7);
            chk("halt_err",     32'(bus_err), 32'd1);
            chk("halt_retired", 32'(retired), 32'(exp_ret));
            chk_quiet("halt");
        end
        do_reset();
        build(OP_LUI, 6'h00, 1'b0, 0, 0, 1'b1);    run_plan(plan_q.size());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
